aes_key_sched_ctrl: RTL

Sequences one shared enc_key_round datapath instance to expand a 128-bit AES cipher key into all 11 round keys (rk0..rk10), one round per clock. It stores the keys in an internal register file and serves them to the encryption round pipeline through a registered read port. It sits between the key-load interface and the AES round datapath, so the round logic never recomputes the schedule per block.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/enc_key_round.sv | 33 +++
 rtl/aes_key_sched_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule controller: round count,
// key/index types, controller FSM states and the byte-level S-box helpers.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] rk_t;
    typedef logic [3:0]   rk_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, which maps 0 to 0) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for rounds 1..10; anything else contributes nothing
    function automatic logic [7:0] rcon(input rk_idx_t r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/enc_key_round.sv
// One AES-128 key-expansion round: derives round key r from round key r-1.
// Purely combinational; the controller registers the result.
module enc_key_round
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [3:0]   round,
    output logic [127:0] key_out
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_temp;
    logic [31:0] w_w4, w_w5, w_w6, w_w7;

    assign w_w0 = key_in[127:96];
    assign w_w1 = key_in[95:64];
    assign w_w2 = key_in[63:32];
    assign w_w3 = key_in[31:0];

    // SubWord(RotWord(w3)) with the round constant folded into the top byte
    assign w_temp = {sbox(w_w3[23:16]) ^ rcon(round),
                     sbox(w_w3[15:8]),
                     sbox(w_w3[7:0]),
                     sbox(w_w3[31:24])};

    assign w_w4 = w_w0 ^ w_temp;
    assign w_w5 = w_w4 ^ w_w1;
    assign w_w6 = w_w5 ^ w_w2;
    assign w_w7 = w_w6 ^ w_w3;

    assign key_out = {w_w4, w_w5, w_w6, w_w7};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: expands a cipher key into rk0..rk10 using a
// single enc_key_round instance (one round per clock), stores the keys and
// serves them through a registered read port.
// Optional build macro AES_KEYSCHED_ZEROIZE_EN enables the zeroize input and
// clears the key store on reset; without it zeroize is ignored and the key
// store has no reset.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = 128
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] key_in,
    input  logic          key_valid,
    output logic          key_ready,
    output logic          keys_valid,
    output logic          busy,
    input  logic [3:0]    rk_addr,
    output logic [KW-1:0] rk_data,
    input  logic          zeroize
);

    localparam rk_idx_t LAST_IDX = rk_idx_t'(NR);

    ks_state_t     r_state, w_state_next;
    logic [KW-1:0] r_work;
    rk_idx_t       r_cnt;
    logic [KW-1:0] r_rk [0:NR];
    logic [KW-1:0] r_rk_data;
    logic [KW-1:0] w_key_out;
    logic [KW-1:0] w_wr_data;
    rk_idx_t       w_wr_idx;
    logic          w_wr_en;
    logic          w_accept;
    logic          w_zero;
    logic          w_key_ready;
    logic          w_keys_valid;
    logic          w_busy;

`ifdef AES_KEYSCHED_ZEROIZE_EN
    assign w_zero = zeroize;
`else
    logic w_unused_zeroize;
    assign w_unused_zeroize = zeroize;
    assign w_zero           = 1'b0;
`endif

    // zeroize wins over a coincident handshake
    assign w_accept = key_valid && w_key_ready && !w_zero;

    enc_key_round u_round (
        .key_in  (r_work),
        .round   (r_cnt),
        .key_out (w_key_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic: accept from IDLE/READY, leave EXPAND after round NR
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, READY: if (w_accept) w_state_next = EXPAND;
            EXPAND:      if (r_cnt == LAST_IDX) w_state_next = READY;
            default:     w_state_next = IDLE;
        endcase
        if (w_zero) w_state_next = IDLE;
    end

    // Output decode from the current state
    always_comb begin
        w_key_ready  = (r_state != EXPAND);
        w_busy       = (r_state == EXPAND);
        w_keys_valid = (r_state == READY);
    end

    // Working key and round counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (w_zero) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_work <= key_in;
            r_cnt  <= 4'd1;
        end else if (r_state == EXPAND) begin
            r_work <= w_key_out;
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    // Single write port: rk0 on accept, rk[cnt] each EXPAND cycle
    assign w_wr_en   = w_accept || ((r_state == EXPAND) && !w_zero);
    assign w_wr_idx  = w_accept ? 4'd0 : r_cnt;
    assign w_wr_data = w_accept ? key_in : w_key_out;

    // Round-key register file
    always_ff @(posedge clk) begin
`ifdef AES_KEYSCHED_ZEROIZE_EN
        if (rst || w_zero) begin
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else
`endif
        if (w_wr_en) r_rk[w_wr_idx] <= w_wr_data;
    end

    // Registered read port; out-of-range indices read as zero
    always_ff @(posedge clk) begin
        if (rst || w_zero)          r_rk_data <= '0;
        else if (rk_addr <= LAST_IDX) r_rk_data <= r_rk[rk_addr];
        else                        r_rk_data <= '0;
    end

    assign key_ready  = w_key_ready;
    assign keys_valid = w_keys_valid;
    assign busy       = w_busy;
    assign rk_data    = r_rk_data;

endmodule
